// File: rtl/mem_defs.sv
// Shared definitions for the memory arbiter and the cache controllers that talk to it.
package mem_defs;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic GRANT_I_SIDE = 1'b0;
  localparam logic GRANT_D_SIDE = 1'b1;

  function automatic arb_state_t grant_state(input logic side);
    return (side == GRANT_D_SIDE) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the side not granted last.
module rr_picker
  import mem_defs::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic valid,
  output logic side
);

  always_comb begin
    valid = req_i | req_d;
    if (req_i && req_d) begin
      side = (last_grant == GRANT_I_SIDE) ? GRANT_D_SIDE : GRANT_I_SIDE;
    end else begin
      side = req_d ? GRANT_D_SIDE : GRANT_I_SIDE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache refill paths, one transaction at a time.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no transaction; pick a requester on the next edge
//   GRANT_I | I-side read in flight on the memory port
//   GRANT_D | D-side read or write in flight on the memory port
//   RELEASE | one cycle: served side sees busywait low and valid readdata
module mem_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       issued;
  logic       i_req, d_req;
  logic       pick_valid, pick_side;
  logic       in_grant;
  logic       mem_done;

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  // issued masks the stale busywait the memory shows on the cycle the strobe first appears
  assign mem_done = issued && !mem_busywait;

  rr_picker u_picker (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .side       (pick_side)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (pick_valid) state_nxt = grant_state(pick_side);
      GRANT_I, GRANT_D: if (mem_done)   state_nxt = RELEASE;
      RELEASE:          state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_grant    <= GRANT_I_SIDE;
      issued        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else if (in_grant) begin
      if (!issued) begin
        issued <= 1'b1;
      end else if (!mem_busywait) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (mem_read) begin
          if (state == GRANT_D) d_readdata <= mem_readdata;
          else                  i_readdata <= mem_readdata;
        end
      end
    end else begin
      issued <= 1'b0;
      if (state == IDLE && pick_valid) begin
        last_grant <= pick_side;
        if (pick_side == GRANT_D_SIDE) begin
          // read and write together is treated as a write
          mem_address   <= d_address;
          mem_writedata <= d_writedata;
          mem_write     <= d_write;
          mem_read      <= !d_write;
        end else begin
          mem_address   <= i_address;
          mem_writedata <= '0;
          mem_write     <= 1'b0;
          mem_read      <= 1'b1;
        end
      end
    end
  end

  // busywait is forced low under reset so a held request does not stall the cache
  assign i_busywait = RESET && i_req && !(state == RELEASE && last_grant == GRANT_I_SIDE);
  assign d_busywait = RESET && d_req && !(state == RELEASE && last_grant == GRANT_D_SIDE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path.
- Sits between both caches and the data memory; each cache sees a private memory-style port with busywait.
- Sequences one memory transaction at a time, with round-robin fairness.

Parameters:
- ADDR_W, 6, block address width.
- DATA_W, 32, block data width.

Ports:
- CLK  in  1  system clock, posedge active.
- RESET  in  1  asynchronous, active-low (0 = reset).
- i_read  in  1  I-side read request, held until served.
- i_address  in  ADDR_W  I-side block address.
- i_readdata  out  DATA_W  I-side returned block.
- i_busywait  out  1  I-side stall.
- d_read  in  1  D-side read request.
- d_write  in  1  D-side write request.
- d_address  in  ADDR_W  D-side block address.
- d_writedata  in  DATA_W  D-side write block.
- d_readdata  out  DATA_W  D-side returned block.
- d_busywait  out  1  D-side stall.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory block address.
- mem_writedata  out  DATA_W  memory write block.
- mem_readdata  in  DATA_W  memory read block.
- mem_busywait  in  1  memory busy.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - All outputs 0; state IDLE; last_grant = I, so D wins the first tie.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - On posedge with pending requests, pick a requester. A single requester always wins. On a tie, the side not equal to last_grant wins.
  - Latch the winner's address, write data and op. Set last_grant.
  - Go to GRANT_I or GRANT_D. With no requests, stay in IDLE.
- GRANT_x:
  - mem_read/mem_write/mem_address/mem_writedata are driven from registers only; nothing is combinational from the requesters.
  - An internal issued flag sets on the first edge in GRANT.
  - On the first posedge with issued = 1 and mem_busywait = 0:
    - Capture mem_readdata into x_readdata (reads only).
    - Clear mem_read/mem_write.
    - Go to RELEASE.
- RELEASE:
  - Lasts exactly 1 cycle, then IDLE.
  - The served side's busywait is 0 during this cycle and its readdata is valid. The requester must drop or change its request at the next edge.
- Busywait (combinational): x_busywait = x_request AND NOT (state == RELEASE AND grant == x).
  - Busywait is 0 whenever the side has no request.
- Readdata registers hold their value until the next read served to that side; they are not cleared in IDLE.
- d_read and d_write both high: treat as a write.
- Request dropped before grant: silently ignored.
- Request dropped during GRANT: the memory op still completes (no abort); the result is still captured and the FSM still goes to RELEASE.
- Back-to-back (both sides requesting continuously): grants strictly alternate. No requester waits more than one full transaction.
- Latency with memory latency L: request at edge 0, grant at edge 1, mem strobe visible after edge 1, RELEASE after edge 1+L, IDLE after edge 2+L.
- Reset mid-transaction: immediate return to IDLE and strobes drop. The memory is expected to be reset alongside.

Decomposition:
- Shared package/header (mem_defs): ADDR_W/DATA_W defaults, state encodings (IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2, RELEASE = 2'd3) and GRANT_I_SIDE/GRANT_D_SIDE constants, for reuse by the cache controllers.
- One natural sub-module, rr_picker: two-input round-robin priority selector, combinational from requests and last_grant. Everything else stays in mem_arbiter.

Test Plan:
- Reset: hold RESET = 0 with i_read = 1 → all outputs 0, i_busywait = 0. Release RESET → mem_read = 1, mem_address = i_address after the next edge.
- Single I read: i_read = 1, i_address = 6'h05, memory returns 32'hDEADBEEF with L = 5 → i_busywait high for 6 cycles, low for exactly 1 cycle with i_readdata = 32'hDEADBEEF.
- Single D write: d_write = 1, d_address = 6'h2A, d_writedata = 32'h12345678 → mem_write = 1 with matching address/data; d_readdata unchanged; d_busywait drops for 1 cycle.
- Simultaneous first requests after reset: i_read and d_read both high → D served first, then I; with both held continuously the grant order is D, I, D, I.
- Withdrawn request: d_read is pulsed for one cycle while I is granted → no D transaction issued; arbiter returns to IDLE after I.
- Reset mid-GRANT: RESET = 0 two cycles into a D read → mem_read and busywaits go 0 immediately; after release the FSM is in IDLE and d_readdata = 0.
